fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of main_controll.
- Holds the PC and issues one request at a time to instruction memory using a valid/ready request and a valid-only response.
- Registers the fetched word and its PC for decode.
- Handles decode stalls and branch redirects, including killing an in-flight fetch.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, word driven on ifid_instruction when the register is invalid or flushed.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_addr  output  XLEN  fetch address; always equals pc.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_resp_valid  input  1  response word valid; one pulse per accepted request.
- imem_resp_data  input  XLEN  fetched instruction.
- stall  input  1  decode cannot accept; IF/ID holds.
- branch_taken  input  1  redirect/flush request, one-cycle pulse.
- branch_target  input  XLEN  redirect PC.
- ifid_valid  output  1  IF/ID holds a live instruction.
- ifid_pc  output  XLEN  PC of ifid_instruction.
- ifid_instruction  output  XLEN  instruction to main_controll; bits [6:0] are the opcode.

Behaviour:
- Reset (async), all registered outputs:
  - pc=RESET_PC, state=REQ, kill=0.
  - ifid_valid=0, ifid_pc=0, ifid_instruction=NOP_INSTR, skid buffer empty.
  - imem_req_valid=0 while reset is high; it asserts the first cycle after release.
- Exactly one outstanding request; no new request issues until the previous response arrives.
- States:
  - REQ: imem_req_valid=1. On imem_req_ready, go to WAIT.
  - WAIT: imem_req_valid=0. On imem_resp_valid:
    - If kill=1: discard the word, clear kill, go to REQ.
    - Else if IF/ID can load (stall=0 or ifid_valid=0): load IF/ID with {1, pc, data}, pc<=pc+4, go to REQ.
    - Else: capture the word in the skid buffer, pc<=pc+4, go to HOLD.
  - HOLD: imem_req_valid=0. When IF/ID frees up, move skid to IF/ID (valid, its PC, its word), go to REQ.
- IF/ID with no new load:
  - If stall=1: hold all three outputs.
  - If stall=0: clear ifid_valid to 0 and set ifid_instruction to NOP_INSTR.
- Latency: response in cycle N → ifid_valid=1 at edge N+1. The next request issues at cycle N+1 at the earliest.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- branch_taken=1 has priority over stall and every state transition:
  - pc<=branch_target; ifid_valid<=0; ifid_instruction<=NOP_INSTR; skid buffer cleared.
  - REQ with no handshake: stay in REQ; the next request uses the new pc.
  - REQ with a handshake that cycle: go to WAIT with kill=1.
  - WAIT without a response that cycle: kill<=1.
  - WAIT with a response that cycle: drop the response, go to REQ.
  - HOLD: go to REQ.
- A response while in REQ or HOLD is a protocol error and is ignored.
- ifid_pc and ifid_instruction are stable whenever ifid_valid=1 and stall=1.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- When defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - If branch_taken=1 and branch_target[1:0]!=0: pc is not updated, fetch_misaligned<=1 (sticky until reset), and the flush still occurs.
  - After that, the unit stays in REQ with imem_req_valid=0.
- When undefined: no port; bits [1:0] of branch_target are forced to 0 when loaded into pc.

Decomposition:
- Shared package: state encoding (REQ, WAIT, HOLD), NOP_INSTR, the RISC-V opcode constants 7'h33, 7'h03, 7'h23, 7'h63 (reused by main_controll), and the PC increment constant 4.
- One sub-module: ifid_reg, a valid/pc/instruction register with load, hold and flush, where flush has priority.

Test Plan:
- Reset release, memory always ready, responses one cycle after acceptance → requests at 0x0, 0x4, 0x8; ifid_pc follows the same sequence, ifid_valid pulses with one bubble between fetches.
- stall=1 for 5 cycles while ifid_valid=1 and a response arrives → IF/ID unchanged; word enters HOLD; after stall drops, IF/ID loads the held word and PC with no loss.
- branch_taken with target 0x100 while in WAIT; late response carries 0xDEADBEEF → response dropped, next request at 0x100, ifid_valid=0 until that response returns.
- branch_taken and stall both high with ifid_valid=1 → ifid_valid=0, ifid_instruction=0x00000013.
- Reset asserted in the middle of WAIT → all outputs return to reset values immediately; after release, the first request is at RESET_PC.
- With FETCH_ALIGN_CHECK_EN: branch_target=0x102 → fetch_misaligned=1, no further requests, pc unchanged.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, NOP word, RV32 opcodes, PC step.
// Also imported by main_controll for the opcode constants.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RV_NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_RTYPE  = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: valid/pc/instruction with load, hold and flush (flush wins).
// With neither load nor stall the slot drains to an invalid NOP.
module ifid_reg #(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic            stall,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instruction
);

    logic            valid_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] instr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            pc_reg    <= '0;
            instr_reg <= NOP_INSTR;
        end else if (flush) begin
            valid_reg <= 1'b0;
            instr_reg <= NOP_INSTR;
        end else if (load) begin
            valid_reg <= 1'b1;
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
        end else if (!stall) begin
            valid_reg <= 1'b0;
            instr_reg <= NOP_INSTR;
        end
    end

    assign valid       = valid_reg;
    assign pc          = pc_reg;
    assign instruction = instr_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with one outstanding imem request, skid buffer and IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky fetch_misaligned flag for unaligned redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(RV_NOP_INSTR)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic            fetch_misaligned,
`endif
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_instruction
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            kill_reg, kill_next;
    logic [XLEN-1:0] skid_pc_reg, skid_pc_next;
    logic [XLEN-1:0] skid_instr_reg, skid_instr_next;

    logic            ifid_load;
    logic            ifid_flush;
    logic [XLEN-1:0] ifid_load_pc;
    logic [XLEN-1:0] ifid_load_instr;
    logic            can_load;
    logic            handshake;
    logic [XLEN-1:0] pc_plus4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_reg, misalign_next;
    assign fetch_misaligned = misalign_reg;
    // Once a bad redirect has been seen the unit parks in REQ without requesting.
    assign imem_req_valid = (state_reg == ST_REQ) && !reset && !misalign_reg;
`else
    assign imem_req_valid = (state_reg == ST_REQ) && !reset;
`endif

    assign imem_req_addr = pc_reg;
    assign handshake     = imem_req_valid && imem_req_ready;
    assign can_load      = !stall || !ifid_valid;
    assign pc_plus4      = pc_reg + XLEN'(PC_INCR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_REQ;
            pc_reg         <= RESET_PC;
            kill_reg       <= 1'b0;
            skid_pc_reg    <= '0;
            skid_instr_reg <= NOP_INSTR;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            kill_reg       <= kill_next;
            skid_pc_reg    <= skid_pc_next;
            skid_instr_reg <= skid_instr_next;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= misalign_next;
        end
    end
`endif

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        kill_next       = kill_reg;
        skid_pc_next    = skid_pc_reg;
        skid_instr_next = skid_instr_reg;
        ifid_load       = 1'b0;
        ifid_flush      = 1'b0;
        ifid_load_pc    = pc_reg;
        ifid_load_instr = imem_resp_data;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_next   = misalign_reg;
`endif

        if (branch_taken) begin
            ifid_flush      = 1'b1;
            skid_pc_next    = '0;
            skid_instr_next = NOP_INSTR;
`ifdef FETCH_ALIGN_CHECK_EN
            if (branch_target[1:0] != 2'b00) begin
                misalign_next = 1'b1;
            end else begin
                pc_next = branch_target;
            end
`else
            pc_next = branch_target & ALIGN_MASK;
`endif
            // An in-flight request cannot be cancelled, so its response is marked for discard.
            unique case (state_reg)
                ST_REQ: begin
                    if (handshake) begin
                        state_next = ST_WAIT;
                        kill_next  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        state_next = ST_REQ;
                        kill_next  = 1'b0;
                    end else begin
                        kill_next = 1'b1;
                    end
                end
                ST_HOLD: state_next = ST_REQ;
                default: state_next = ST_REQ;
            endcase
        end else begin
            unique case (state_reg)
                ST_REQ: begin
                    if (handshake) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        if (kill_reg) begin
                            kill_next  = 1'b0;
                            state_next = ST_REQ;
                        end else if (can_load) begin
                            ifid_load  = 1'b1;
                            pc_next    = pc_plus4;
                            state_next = ST_REQ;
                        end else begin
                            skid_pc_next    = pc_reg;
                            skid_instr_next = imem_resp_data;
                            pc_next         = pc_plus4;
                            state_next      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (can_load) begin
                        ifid_load       = 1'b1;
                        ifid_load_pc    = skid_pc_reg;
                        ifid_load_instr = skid_instr_reg;
                        state_next      = ST_REQ;
                    end
                end
                default: state_next = ST_REQ;
            endcase
        end
    end

    ifid_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk         (clk),
        .reset       (reset),
        .load        (ifid_load),
        .flush       (ifid_flush),
        .stall       (stall),
        .load_pc     (ifid_load_pc),
        .load_instr  (ifid_load_instr),
        .valid       (ifid_valid),
        .pc          (ifid_pc),
        .instruction (ifid_instruction)
    );

endmodule
